// File: rtl/fse_lms_csr_bank_pkg.sv
// rtl/fse_lms_csr_bank_pkg.sv - register map, bit positions and reset values for the FSE-LMS CSR bank
package fse_lms_csr_pkg;

    localparam int unsigned ADDR_ID       = 32'h00;
    localparam int unsigned ADDR_CTRL     = 32'h01;
    localparam int unsigned ADDR_MU       = 32'h02;
    localparam int unsigned ADDR_LEAK     = 32'h03;
    localparam int unsigned ADDR_COEF_IDX = 32'h04;
    localparam int unsigned ADDR_COEF_LO  = 32'h05;
    localparam int unsigned ADDR_COEF_HI  = 32'h06;
    localparam int unsigned ADDR_STATUS   = 32'h07;
    localparam int unsigned ADDR_SCRATCH  = 32'h08;

    localparam int unsigned CTRL_RUN      = 0;
    localparam int unsigned CTRL_ADAPT_EN = 1;
    localparam int unsigned CTRL_FREEZE   = 2;
    localparam int unsigned CTRL_SOFT_RST = 7;

    localparam int unsigned STAT_BUSY     = 0;
    localparam int unsigned STAT_LOCK_ERR = 1;
    localparam int unsigned STAT_BAD_ADDR = 2;

    localparam int unsigned REG_BITS  = 8;
    localparam int unsigned COEF_BITS = 16;

    localparam logic [REG_BITS-1:0] MU_RST   = 8'h04;
    localparam logic [REG_BITS-1:0] LEAK_RST = 8'h00;

    typedef enum logic [3:0] {
        SEL_ID,
        SEL_CTRL,
        SEL_MU,
        SEL_LEAK,
        SEL_COEF_IDX,
        SEL_COEF_LO,
        SEL_COEF_HI,
        SEL_STATUS,
        SEL_SCRATCH,
        SEL_NONE
    } reg_sel_e;

    // Shared by the write and read paths so both agree on which addresses exist.
    function automatic reg_sel_e decode_addr(input int unsigned a);
        reg_sel_e s;
        case (a)
            ADDR_ID:       s = SEL_ID;
            ADDR_CTRL:     s = SEL_CTRL;
            ADDR_MU:       s = SEL_MU;
            ADDR_LEAK:     s = SEL_LEAK;
            ADDR_COEF_IDX: s = SEL_COEF_IDX;
            ADDR_COEF_LO:  s = SEL_COEF_LO;
            ADDR_COEF_HI:  s = SEL_COEF_HI;
            ADDR_STATUS:   s = SEL_STATUS;
            ADDR_SCRATCH:  s = SEL_SCRATCH;
            default:       s = SEL_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fse_lms_csr_bank_if.sv
// rtl/fse_lms_csr_bank_if.sv - register access bus between the SPI slave and the CSR bank
interface fse_lms_csr_bank_if #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8
);
    logic                 wr_en;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wr_data;
    logic [DATA_BITS-1:0] rd_data;

    modport master (output wr_en, output addr, output wr_data, input rd_data);
    modport slave  (input wr_en, input addr, input wr_data, output rd_data);
endinterface

// File: rtl/fse_lms_csr_bank_coef_store.sv
// rtl/fse_lms_csr_bank_coef_store.sv - NUM_TAPS x 16-bit coefficient flops with one write port
module fse_lms_coef_store
    import fse_lms_csr_pkg::*;
#(
    parameter int NUM_TAPS = 8,
    parameter int IDX_BITS = $clog2(NUM_TAPS)
) (
    input  logic                          sclk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          we,
    input  logic [IDX_BITS-1:0]           idx,
    input  logic [COEF_BITS-1:0]          wdata,
    output logic [NUM_TAPS*COEF_BITS-1:0] coef_flat,
    output logic [COEF_BITS-1:0]          rd_coef
);

    logic [COEF_BITS-1:0] coef_q [NUM_TAPS];

    // Async reset, sync clear (soft reset) takes priority over a write.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) coef_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < NUM_TAPS; i++) coef_q[i] <= '0;
        end else if (we) begin
            coef_q[idx] <= wdata;
        end
    end

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_flat
        assign coef_flat[g*COEF_BITS +: COEF_BITS] = coef_q[g];
    end

    assign rd_coef = coef_q[idx];

endmodule

// File: rtl/fse_lms_csr_bank.sv
// rtl/fse_lms_csr_bank.sv - FSE-LMS equaliser control/status register bank
module fse_lms_csr_bank
    import fse_lms_csr_pkg::*;
#(
    parameter int                 ADDR_BITS = 7,
    parameter int                 DATA_BITS = 8,
    parameter int                 NUM_TAPS  = 8,
    parameter logic [7:0]         ID_VALUE  = 8'hA5
) (
    input  logic                          sclk,
    input  logic                          rst_n,
    fse_lms_csr_bank_if.slave             bus,
    input  logic                          core_busy,
    output logic                          ctrl_run,
    output logic                          ctrl_adapt_en,
    output logic                          ctrl_freeze,
    output logic                          soft_rst_pulse,
    output logic [7:0]                    mu,
    output logic [7:0]                    leak,
    output logic [NUM_TAPS*COEF_BITS-1:0] coef_flat,
    output logic                          coef_update
);

    localparam int IDX_BITS = $clog2(NUM_TAPS);

    logic [ADDR_BITS-1:0] addr_l;
    logic [REG_BITS-1:0]  wr8;
    logic [REG_BITS-1:0]  rd8;
    reg_sel_e             sel;

    logic [2:0]           ctrl_q, ctrl_d;
    logic [REG_BITS-1:0]  mu_q, mu_d;
    logic [REG_BITS-1:0]  leak_q, leak_d;
    logic [IDX_BITS-1:0]  idx_q, idx_d;
    logic [REG_BITS-1:0]  lo_q, lo_d;
    logic [REG_BITS-1:0]  scratch_q, scratch_d;
    logic                 lock_err_q, lock_err_d;
    logic                 bad_addr_q, bad_addr_d;
    logic                 soft_rst_q, soft_rst_d;
    logic                 coef_upd_q, coef_upd_d;
    logic                 coef_we, coef_clr;
    logic [COEF_BITS-1:0] rd_coef;

    assign addr_l = bus.addr;
    assign wr8    = bus.wr_data[REG_BITS-1:0];
    assign sel    = decode_addr(32'(addr_l));

    // Write decode: next-state for every register plus the one-cycle pulses.
    always_comb begin
        ctrl_d     = ctrl_q;
        mu_d       = mu_q;
        leak_d     = leak_q;
        idx_d      = idx_q;
        lo_d       = lo_q;
        scratch_d  = scratch_q;
        lock_err_d = lock_err_q;
        bad_addr_d = bad_addr_q;
        soft_rst_d = 1'b0;
        coef_upd_d = 1'b0;
        coef_we    = 1'b0;
        coef_clr   = 1'b0;
        if (bus.wr_en) begin
            case (sel)
                SEL_CTRL: begin
                    if (wr8[CTRL_SOFT_RST]) begin
                        ctrl_d     = '0;
                        mu_d       = MU_RST;
                        leak_d     = LEAK_RST;
                        idx_d      = '0;
                        lo_d       = '0;
                        lock_err_d = 1'b0;
                        bad_addr_d = 1'b0;
                        coef_clr   = 1'b1;
                        soft_rst_d = 1'b1;
                    end else begin
                        ctrl_d = wr8[2:0];
                    end
                end
                SEL_MU: begin
                    if (ctrl_q[CTRL_RUN]) lock_err_d = 1'b1;
                    else                  mu_d       = wr8;
                end
                SEL_LEAK: begin
                    if (ctrl_q[CTRL_RUN]) lock_err_d = 1'b1;
                    else                  leak_d     = wr8;
                end
                SEL_COEF_IDX: idx_d = wr8[IDX_BITS-1:0];
                SEL_COEF_LO:  lo_d  = wr8;
                SEL_COEF_HI: begin
                    if (ctrl_q[CTRL_RUN]) begin
                        lock_err_d = 1'b1;
                    end else begin
                        coef_we    = 1'b1;
                        coef_upd_d = 1'b1;
                        idx_d      = idx_q + IDX_BITS'(1);
                    end
                end
                SEL_STATUS: begin
                    if (wr8[STAT_LOCK_ERR]) lock_err_d = 1'b0;
                    if (wr8[STAT_BAD_ADDR]) bad_addr_d = 1'b0;
                end
                SEL_SCRATCH: scratch_d  = wr8;
                SEL_ID:      ;
                default:     bad_addr_d = 1'b1;
            endcase
        end
    end

    // Register state; all config is held in the sclk domain.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            mu_q       <= MU_RST;
            leak_q     <= LEAK_RST;
            idx_q      <= '0;
            lo_q       <= '0;
            scratch_q  <= '0;
            lock_err_q <= 1'b0;
            bad_addr_q <= 1'b0;
            soft_rst_q <= 1'b0;
            coef_upd_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            mu_q       <= mu_d;
            leak_q     <= leak_d;
            idx_q      <= idx_d;
            lo_q       <= lo_d;
            scratch_q  <= scratch_d;
            lock_err_q <= lock_err_d;
            bad_addr_q <= bad_addr_d;
            soft_rst_q <= soft_rst_d;
            coef_upd_q <= coef_upd_d;
        end
    end

    fse_lms_coef_store #(
        .NUM_TAPS (NUM_TAPS),
        .IDX_BITS (IDX_BITS)
    ) u_coef_store (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .clr       (coef_clr),
        .we        (coef_we),
        .idx       (idx_q),
        .wdata     ({wr8, lo_q}),
        .coef_flat (coef_flat),
        .rd_coef   (rd_coef)
    );

    // Read mux: purely combinational, no side effects on any access.
    always_comb begin
        rd8 = '0;
        case (sel)
            SEL_ID:       rd8 = ID_VALUE;
            SEL_CTRL:     rd8 = {5'b0, ctrl_q};
            SEL_MU:       rd8 = mu_q;
            SEL_LEAK:     rd8 = leak_q;
            SEL_COEF_IDX: rd8 = REG_BITS'(idx_q);
            SEL_COEF_LO:  rd8 = rd_coef[7:0];
            SEL_COEF_HI:  rd8 = rd_coef[15:8];
            SEL_STATUS:   rd8 = {5'b0, bad_addr_q, lock_err_q, core_busy};
            SEL_SCRATCH:  rd8 = scratch_q;
            default:      rd8 = '0;
        endcase
    end

    assign bus.rd_data    = DATA_BITS'(rd8);
    assign ctrl_run       = ctrl_q[CTRL_RUN];
    assign ctrl_adapt_en  = ctrl_q[CTRL_ADAPT_EN];
    assign ctrl_freeze    = ctrl_q[CTRL_FREEZE];
    assign soft_rst_pulse = soft_rst_q;
    assign coef_update    = coef_upd_q;
    assign mu             = mu_q;
    assign leak           = leak_q;

endmodule

// File: tb/tb_fse_lms_csr_bank.sv
// tb/tb_fse_lms_csr_bank.sv - self-checking bench for fse_lms_csr_bank
module tb_fse_lms_csr_bank;

    localparam int NT = 8;

    logic          sclk = 1'b0;
    logic          rst_n = 1'b1;
    logic          core_busy = 1'b0;
    logic          ctrl_run, ctrl_adapt_en, ctrl_freeze, soft_rst_pulse, coef_update;
    logic [7:0]    mu, leak;
    logic [NT*16-1:0] coef_flat;

    fse_lms_csr_bank_if #(.ADDR_BITS(7), .DATA_BITS(8)) bus ();

    fse_lms_csr_bank #(
        .ADDR_BITS (7),
        .DATA_BITS (8),
        .NUM_TAPS  (NT),
        .ID_VALUE  (8'hA5)
    ) dut (
        .sclk           (sclk),
        .rst_n          (rst_n),
        .bus            (bus),
        .core_busy      (core_busy),
        .ctrl_run       (ctrl_run),
        .ctrl_adapt_en  (ctrl_adapt_en),
        .ctrl_freeze    (ctrl_freeze),
        .soft_rst_pulse (soft_rst_pulse),
        .mu             (mu),
        .leak           (leak),
        .coef_flat      (coef_flat),
        .coef_update    (coef_update)
    );

    always #5 sclk = ~sclk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: registers as plain variables, coefficients as an array.
    bit [2:0]  m_ctrl;
    bit [7:0]  m_mu, m_leak, m_lo, m_scratch;
    int        m_idx;
    bit [15:0] m_coef [NT];
    bit        m_lock, m_bad, m_cu, m_sr;

    task automatic model_reset(input bit keep_scratch);
        m_ctrl = 0; m_mu = 8'h04; m_leak = 0; m_lo = 0; m_idx = 0;
        m_lock = 0; m_bad = 0; m_cu = 0; m_sr = 0;
        for (int i = 0; i < NT; i++) m_coef[i] = 0;
        if (!keep_scratch) m_scratch = 0;
    endtask

    task automatic model_write(input int a, input bit [7:0] d);
        bit run;
        run = m_ctrl[0];
        m_cu = 0; m_sr = 0;
        case (a)
            0: ;
            1: if (d[7]) begin model_reset(1); m_sr = 1; end else m_ctrl = d[2:0];
            2: if (run) m_lock = 1; else m_mu = d;
            3: if (run) m_lock = 1; else m_leak = d;
            4: m_idx = d % NT;
            5: m_lo = d;
            6: if (run) m_lock = 1;
               else begin
                   m_coef[m_idx] = {d, m_lo};
                   m_idx = (m_idx + 1) % NT;
                   m_cu = 1;
               end
            7: begin if (d[1]) m_lock = 0; if (d[2]) m_bad = 0; end
            8: m_scratch = d;
            default: m_bad = 1;
        endcase
    endtask

    function automatic bit [7:0] model_read(input int a);
        case (a)
            0: return 8'hA5;
            1: return {5'b0, m_ctrl};
            2: return m_mu;
            3: return m_leak;
            4: return 8'(m_idx);
            5: return m_coef[m_idx][7:0];
            6: return m_coef[m_idx][15:8];
            7: return {5'b0, m_bad, m_lock, core_busy};
            8: return m_scratch;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [NT*16-1:0] model_flat();
        logic [NT*16-1:0] f;
        for (int i = 0; i < NT; i++) f[i*16 +: 16] = m_coef[i];
        return f;
    endfunction

    task automatic chk_state();
        chk("ctrl_run", ctrl_run, m_ctrl[0]);
        chk("ctrl_adapt_en", ctrl_adapt_en, m_ctrl[1]);
        chk("ctrl_freeze", ctrl_freeze, m_ctrl[2]);
        chk("mu", mu, m_mu);
        chk("leak", leak, m_leak);
        chk("coef_flat", coef_flat, model_flat());
        chk("coef_update", coef_update, m_cu);
        chk("soft_rst_pulse", soft_rst_pulse, m_sr);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        @(negedge sclk);
        bus.wr_en = 1'b1; bus.addr = a; bus.wr_data = d;
        model_write(int'(a), d);
        @(posedge sclk);
        #1;
        bus.wr_en = 1'b0;
        chk_state();
    endtask

    task automatic do_read(input logic [6:0] a, input bit use_exp, input logic [7:0] exp);
        @(negedge sclk);
        bus.addr = a;
        #1;
        chk($sformatf("rd_model_%02h", a), bus.rd_data, model_read(int'(a)));
        if (use_exp) chk($sformatf("rd_const_%02h", a), bus.rd_data, exp);
    endtask

    typedef struct {
        bit         wr;
        logic [6:0] a;
        logic [7:0] d;   // write data, or expected read value
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit wr, input logic [6:0] a, input logic [7:0] d);
        vec_t v;
        v.wr = wr; v.a = a; v.d = d;
        tbl.push_back(v);
    endfunction

    initial begin
        bus.wr_en = 1'b0; bus.addr = '0; bus.wr_data = '0;
        model_reset(0);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge sclk);
        @(negedge sclk) rst_n = 1'b1;

        // Reset state
        #1;
        chk("rst_rd_id", bus.rd_data, 8'hA5);
        chk("rst_mu", mu, 8'h04);
        chk("rst_flat", coef_flat, '0);
        chk("rst_pulses", {coef_update, soft_rst_pulse}, 2'b00);
        chk_state();

        // Coefficient load with index wrap, checked by hand
        do_write(7'h04, 8'h07);
        do_write(7'h05, 8'h34);
        do_write(7'h06, 8'h12);
        chk("coef7", coef_flat[7*16 +: 16], 16'h1234);
        chk("cu_high", coef_update, 1'b1);
        @(posedge sclk); #1;
        chk("cu_drop", coef_update, 1'b0);

        // Directed table
        add(0, 7'h00, 8'hA5); add(0, 7'h02, 8'h04); add(0, 7'h08, 8'h00);
        add(0, 7'h04, 8'h00);
        add(1, 7'h04, 8'h07); add(0, 7'h05, 8'h34); add(0, 7'h06, 8'h12);
        add(0, 7'h04, 8'h07);
        add(1, 7'h01, 8'h01); add(1, 7'h02, 8'h09); add(0, 7'h02, 8'h04);
        add(0, 7'h07, 8'h02); add(1, 7'h07, 8'h02); add(0, 7'h07, 8'h00);
        add(1, 7'h06, 8'h99); add(0, 7'h04, 8'h07); add(0, 7'h06, 8'h12);
        add(0, 7'h07, 8'h02); add(1, 7'h07, 8'h02);
        add(1, 7'h2A, 8'h55); add(0, 7'h07, 8'h04); add(0, 7'h2A, 8'h00);
        add(1, 7'h07, 8'h04); add(0, 7'h07, 8'h00);
        add(1, 7'h01, 8'h7E); add(0, 7'h01, 8'h06);
        add(1, 7'h01, 8'h00); add(1, 7'h08, 8'h5A); add(0, 7'h08, 8'h5A);
        add(1, 7'h04, 8'hF9); add(0, 7'h04, 8'h01);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].wr) do_write(tbl[i].a, tbl[i].d);
            else           do_read(tbl[i].a, 1'b1, tbl[i].d);
        end

        // Live busy bit
        core_busy = 1'b1;
        do_read(7'h07, 1'b1, 8'h01);
        core_busy = 1'b0;

        // Soft reset after loading three taps
        do_write(7'h04, 8'h00);
        do_write(7'h05, 8'h11); do_write(7'h06, 8'h22);
        do_write(7'h05, 8'h33); do_write(7'h06, 8'h44);
        do_write(7'h05, 8'h55); do_write(7'h06, 8'h66);
        chk("pre_srst_coef2", coef_flat[2*16 +: 16], 16'h6655);
        do_write(7'h02, 8'h21);
        do_write(7'h01, 8'h83);
        chk("srst_pulse", soft_rst_pulse, 1'b1);
        chk("srst_flat", coef_flat, '0);
        chk("srst_mu", mu, 8'h04);
        @(posedge sclk); #1;
        chk("srst_drop", soft_rst_pulse, 1'b0);
        do_read(7'h01, 1'b1, 8'h00);
        do_read(7'h08, 1'b1, 8'h5A);
        do_read(7'h04, 1'b1, 8'h00);

        // Randomised traffic against the model
        for (int n = 0; n < 300; n++) begin
            logic [6:0] a;
            logic [7:0] d;
            if ($urandom_range(0, 9) < 8) a = 7'($urandom_range(0, 8));
            else                          a = 7'($urandom_range(0, 127));
            d = 8'($urandom);
            if (a == 7'h01 && ($urandom_range(0, 5) != 0)) d[7] = 1'b0;
            core_busy = 1'($urandom_range(0, 1));
            do_write(a, d);
            do_read(7'($urandom_range(0, 15)), 1'b0, 8'h00);
        end
        core_busy = 1'b0;

        // Asynchronous reset mid-frame with a pending write
        do_write(7'h01, 8'h00);
        do_write(7'h02, 8'h33);
        do_write(7'h04, 8'h03);
        do_write(7'h05, 8'hCD); do_write(7'h06, 8'hAB);
        do_write(7'h08, 8'h77);
        @(negedge sclk);
        bus.wr_en = 1'b1; bus.addr = 7'h08; bus.wr_data = 8'h11;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mu", mu, 8'h04);
        chk("arst_flat", coef_flat, '0);
        chk("arst_scratch", bus.rd_data, 8'h00);
        @(posedge sclk); #1;
        chk("arst_nocommit", bus.rd_data, 8'h00);
        chk("arst_cu", coef_update, 1'b0);
        bus.wr_en = 1'b0;
        @(negedge sclk) rst_n = 1'b1;
        model_reset(0);
        do_read(7'h08, 1'b1, 8'h00);
        do_read(7'h00, 1'b1, 8'hA5);
        chk_state();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
